i2c_master_sequencer: RTL and testbench
=======================================

I2C_MASTER_SEQUENCER -- requirements
Module: i2c_master_sequencer

Interface
REQ-001 clock  in  1  system clock; all logic on posedge clock.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 scl  in  1  free-running bus clock from the clock generator.
REQ-004 cl_low  in  1  one-cycle strobe at mid-low of scl; SDA changes only here.
REQ-005 cl_high  in  1  one-cycle strobe at mid-high of scl; SDA sampled or START/STOP only here.
REQ-006 start  in  1  request pulse; accepted only when busy=0.
REQ-007 dev_addr  in  7  target device address, latched on accept.
REQ-008 reg_addr  in  8  register address byte, latched on accept.
REQ-009 wr_data  in  8  data byte, latched on accept.
REQ-010 sda_in  in  1  sampled SDA pin level.
REQ-011 scl_out  out  1  gated bus clock: scl when gate=1, else constant 1.
REQ-012 sda_oe  out  1  open-drain drive: 1 = pull SDA low, 0 = release.
REQ-013 busy  out  1  high from cycle after accept until done pulse.
REQ-014 done  out  1  one-cycle pulse when STOP is issued.
REQ-015 ack_error  out  1  sticky NACK flag; cleared on next accept.

Function
REQ-016 The block SHALL perform one write transaction: START, {dev_addr,0}, ACK, reg_addr, ACK, wr_data, ACK, STOP.
REQ-017 States SHALL be IDLE, WAIT_START, SEND_BIT, ACK_REL, ACK_SAMPLE, STOP_LOW, STOP_HIGH, STOP; byte index 2-bit, bit index 3-bit.
REQ-018 IDLE: start=1 -> latch inputs, clear ack_error, go WAIT_START; busy=1 next cycle; start while busy SHALL be ignored.
REQ-019 WAIT_START: on first cl_high after the accept cycle (never the same cycle), sda_oe<=1 (START), gate<=1, go SEND_BIT.
REQ-020 SEND_BIT: each cl_low, sda_oe<=~bit, MSB first; after 8th bit, next cl_low -> ACK_REL.
REQ-021 ACK_REL: on entry cl_low, sda_oe<=0; next cl_high -> ACK_SAMPLE action: sda_in=0 is ACK, 1 is NACK.
REQ-022 After ACK of bytes 0 and 1, SHALL continue SEND_BIT with next byte; after byte 2 -> STOP_LOW.
REQ-023 STOP_LOW: next cl_low, sda_oe<=1; STOP_HIGH: next cl_high, gate<=0 (scl_out stays 1).
REQ-024 STOP: next cl_low, sda_oe<=0 (SDA rises with SCL high), done=1 for one cycle, busy<=0, IDLE.
REQ-025 scl_out SHALL show exactly 28 rising edges per full transaction (27 data/ACK clocks + 1 STOP).
REQ-026 strobes arriving in states not waiting on them SHALL be ignored; cl_low and cl_high are never simultaneous.
REQ-027 start coincident with done cycle SHALL be ignored (busy still 1 that cycle).

Reset
REQ-028 reset SHALL force within one edge: IDLE, scl_out=1, sda_oe=0, busy=0, done=0, ack_error=0, counters 0.
REQ-029 reset mid-transaction SHALL abort without emitting STOP; bus released immediately.
REQ-030 reset has priority over start and strobes in the same cycle.

Configuration
REQ-031 Macro I2C_ACK_CHECK_EN defined: NACK sets ack_error=1 and jumps to STOP_LOW, skipping remaining bytes.
REQ-032 Macro I2C_ACK_CHECK_EN undefined: sda_in ignored, ack_error tied 0, all three bytes always sent.

Verification
REQ-033 dev_addr=7'h50, reg_addr=8'h10, wr_data=8'hA5, sda_in=0 at ACKs -> SDA bytes A0,10,A5; 28 scl_out rises; done once; ack_error=0.
REQ-034 START/STOP check: sda_oe rises while scl_out=1 at START; sda_oe falls while scl_out=1 at STOP.
REQ-035 With I2C_ACK_CHECK_EN, sda_in=1 at first ACK -> ack_error=1, 10 scl_out rises, STOP, done; without macro -> 28 rises, ack_error=0.
REQ-036 start pulsed mid-transaction with different data -> ignored; transmitted bytes unchanged.
REQ-037 reset asserted during byte 1 bit 4 -> next cycle scl_out=1, sda_oe=0, busy=0; new start then runs full transaction correctly.

Source files
------------

// File: rtl/i2c_master_sequencer.sv
// Single-transaction I2C write sequencer: START, {dev_addr,0}, reg_addr, wr_data, STOP.
// Optional macro I2C_ACK_CHECK_EN enables NACK detection with early STOP.
module i2c_master_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  input  logic       cl_low,
  input  logic       cl_high,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error
);

`ifdef I2C_ACK_CHECK_EN
  localparam bit AckCheck = 1'b1;
`else
  localparam bit AckCheck = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, WAIT_START, SEND_BIT, ACK_REL, ACK_SAMPLE, STOP_LOW, STOP_HIGH, STOP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       rel_pend_q, rel_pend_d;
  logic       gate_q, gate_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_error_q, ack_error_d;
  logic       nack_q, nack_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic [7:0] cur_byte;

  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = {dev_q, 1'b0};
      2'd1:    cur_byte = reg_q;
      default: cur_byte = data_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    rel_pend_d  = rel_pend_q;
    gate_d      = gate_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_error_d = ack_error_q;
    nack_d      = nack_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        // busy is held through the done cycle so a coincident start is ignored
        if (done_q) begin
          busy_d = 1'b0;
        end else if (start && !busy_q) begin
          dev_d       = dev_addr;
          reg_d       = reg_addr;
          data_d      = wr_data;
          ack_error_d = 1'b0;
          nack_d      = 1'b0;
          busy_d      = 1'b1;
          byte_idx_d  = 2'd0;
          bit_idx_d   = 3'd7;
          rel_pend_d  = 1'b0;
          state_d     = WAIT_START;
        end
      end
      WAIT_START: begin
        if (cl_high) begin
          sda_oe_d = 1'b1;
          gate_d   = 1'b1;
          state_d  = SEND_BIT;
        end
      end
      SEND_BIT: begin
        // nine cl_low slots per byte: eight data bits, then the ACK release
        if (cl_low) begin
          if (rel_pend_q) begin
            sda_oe_d   = 1'b0;
            rel_pend_d = 1'b0;
            state_d    = ACK_REL;
          end else begin
            sda_oe_d = ~cur_byte[bit_idx_q];
            if (bit_idx_q == 3'd0) rel_pend_d = 1'b1;
            else                   bit_idx_d  = bit_idx_q - 3'd1;
          end
        end
      end
      ACK_REL: begin
        if (cl_high) begin
          nack_d  = AckCheck & sda_in;
          state_d = ACK_SAMPLE;
        end
      end
      ACK_SAMPLE: begin
        if (nack_q) begin
          ack_error_d = 1'b1;
          state_d     = STOP_LOW;
        end else if (byte_idx_q == 2'd2) begin
          state_d = STOP_LOW;
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
          bit_idx_d  = 3'd7;
          state_d    = SEND_BIT;
        end
      end
      STOP_LOW: begin
        if (cl_low) begin
          sda_oe_d = 1'b1;
          state_d  = STOP_HIGH;
        end
      end
      STOP_HIGH: begin
        if (cl_high) begin
          gate_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cl_low) begin
          sda_oe_d   = 1'b0;
          done_d     = 1'b1;
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      bit_idx_q   <= '0;
      rel_pend_q  <= 1'b0;
      gate_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      nack_q      <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      rel_pend_q  <= rel_pend_d;
      gate_q      <= gate_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_error_q <= ack_error_d;
      nack_q      <= nack_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
    end
  end

  assign scl_out   = gate_q ? scl : 1'b1;
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Scoreboard bench: bus-level monitor decodes START/bits/STOP from scl_out/sda_oe and
// compares each completed transaction against a byte-level reference model.
module tb_i2c_master_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b0, cl_low = 1'b0, cl_high = 1'b0;
  logic       start = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0, wr_data = '0;
  logic       sda_in = 1'b1;
  logic       scl_out, sda_oe, busy, done, ack_error;

  int checks = 0, failures = 0;
  int done_cnt = 0, n_txn = 0, mon_rises = 0;
  logic [2:0] cur_pat = '0;

  typedef struct {
    int          rises;
    logic [31:0] bits;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  logic        m_pscl = 1'b1, m_poe = 1'b0, m_pdone = 1'b0;
  logic        m_started = 1'b0, m_stopped = 1'b0;
  logic [31:0] m_sh = '0;
  exp_t        m_e;

  i2c_master_sequencer dut (
    .clock(clock), .reset(reset), .scl(scl), .cl_low(cl_low), .cl_high(cl_high),
    .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .sda_in(sda_in), .scl_out(scl_out), .sda_oe(sda_oe), .busy(busy), .done(done),
    .ack_error(ack_error)
  );

  initial forever #5 clock = ~clock;

  // Bus clock of 8 system cycles: low in phases 0-3, high in 4-7, strobes mid-phase.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clock);
      #1;
      phase   = (phase + 1) % 8;
      scl     = (phase >= 4);
      cl_low  = (phase == 2);
      cl_high = (phase == 6);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected bit levels seen at each scl_out rise: data bits, released ACK slot, STOP clock with SDA low.
  function automatic exp_t model(input logic [6:0] d, input logic [7:0] r,
                                 input logic [7:0] w, input logic [2:0] pat);
    exp_t e;
    logic [7:0] b [3];
    int n;
    b[0] = {d, 1'b0};
    b[1] = r;
    b[2] = w;
    n = 3;
    e.err = 1'b0;
`ifdef I2C_ACK_CHECK_EN
    for (int k = 2; k >= 0; k--) begin
      if (pat[k]) begin
        n = k + 1;
        e.err = 1'b1;
      end
    end
`endif
    e.bits = '0;
    e.rises = 0;
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) e.bits = {e.bits[30:0], b[k][i]};
      e.bits = {e.bits[30:0], 1'b1};
      e.rises += 9;
    end
    e.bits = {e.bits[30:0], 1'b0};
    e.rises += 1;
    return e;
  endfunction

  // Monitor and ACK responder.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        m_started = 1'b0;
        m_stopped = 1'b0;
        m_sh      = '0;
        mon_rises = 0;
        sda_in    = 1'b1;
        m_pscl    = scl_out;
        m_poe     = sda_oe;
        m_pdone   = 1'b0;
      end else begin
        if (m_pscl && scl_out && !m_poe && sda_oe) begin
          m_started = 1'b1;
          m_stopped = 1'b0;
          m_sh      = '0;
          mon_rises = 0;
        end
        if (m_pscl && scl_out && m_poe && !sda_oe) m_stopped = 1'b1;
        if (!m_pscl && scl_out) begin
          mon_rises++;
          m_sh = {m_sh[30:0], ~sda_oe};
        end
        sda_in = (mon_rises > 0 && mon_rises % 9 == 0 && mon_rises <= 27)
                 ? cur_pat[mon_rises/9 - 1] : 1'b1;
        if (m_pdone) check("done_one_cycle", {31'b0, done}, 32'd0);
        if (done && !m_pdone) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no transaction pending");
          end else begin
            m_e = exp_q.pop_front();
            check("scl_rises", mon_rises, m_e.rises);
            check("sda_bits", m_sh, m_e.bits);
            check("ack_error", {31'b0, ack_error}, {31'b0, m_e.err});
            check("start_cond", {31'b0, m_started}, 32'd1);
            check("stop_cond", {31'b0, m_stopped}, 32'd1);
          end
          m_started = 1'b0;
          m_stopped = 1'b0;
        end
        m_pscl  = scl_out;
        m_poe   = sda_oe;
        m_pdone = done;
      end
    end
  end

  task automatic run_txn(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                         input logic [2:0] pat, input bit inject, input bit done_start);
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 5000) begin @(negedge clock); n++; end
    if (busy) begin
      checks++; failures++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
      return;
    end
    dev_addr = d; reg_addr = r; wr_data = w; cur_pat = pat;
    start = 1'b1;
    exp_q.push_back(model(d, r, w, pat));
    n_txn++;
    @(negedge clock);
    start = 1'b0;
    dev_addr = ~d; reg_addr = ~r; wr_data = ~w;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    if (inject) begin
      repeat ($urandom_range(20, 60)) @(negedge clock);
      if (busy && !done) begin
        start = 1'b1;
        dev_addr = 7'($urandom); reg_addr = 8'($urandom); wr_data = 8'($urandom);
        @(negedge clock);
        start = 1'b0;
      end
    end
    n = 0;
    while (!done && n < 5000) begin @(negedge clock); n++; end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout: got done=0 expected 1");
      return;
    end
    if (done_start) begin
      start = 1'b1;
      dev_addr = 7'($urandom); reg_addr = 8'($urandom); wr_data = 8'($urandom);
      @(negedge clock);
      start = 1'b0;
      check("start_on_done_ignored", {31'b0, busy}, 32'd0);
    end else begin
      @(negedge clock);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check("rst_scl_out", {31'b0, scl_out}, 32'd1);
    check("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ack_error", {31'b0, ack_error}, 32'd0);
    reset = 1'b0;

    run_txn(7'h50, 8'h10, 8'hA5, 3'b000, 1'b0, 1'b0);
    run_txn(7'h50, 8'h10, 8'hA5, 3'b001, 1'b0, 1'b1);
    run_txn(7'h2B, 8'h3C, 8'h00, 3'b000, 1'b1, 1'b0);
    for (int t = 0; t < 8; t++) begin
      run_txn(7'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
              1'($urandom), 1'($urandom));
    end

    // Abort during byte 1, bit 4; no STOP and no done expected.
    @(negedge clock);
    dev_addr = 7'h33; reg_addr = 8'hC3; wr_data = 8'h5A; cur_pat = 3'b000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (mon_rises < 13 && n < 5000) begin @(negedge clock); n++; end
    check("abort_reached_bit", {31'b0, mon_rises >= 13}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_scl_out", {31'b0, scl_out}, 32'd1);
    check("abort_sda_oe", {31'b0, sda_oe}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    run_txn(7'h50, 8'h10, 8'hA5, 3'b000, 1'b0, 1'b0);

    repeat (20) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("done_count", done_cnt, n_txn);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
